branch_unit_mc: RTL
===================

# branch_unit_mc

Multi-port branch resolution unit with registered outputs, mispredict arbitration and a buffered predictor-update queue. It resolves up to NrBrPorts control-flow instructions per cycle from the issue stage. It reports at most one (oldest) mispredict to the frontend and ID stage, and halts further resolution until the controller flushes. Every resolved outcome is queued for BHT/BTB training, and the queue applies backpressure to issue when it cannot absorb a full cycle of results.

## Interface
- NrBrPorts, 2: parallel resolution ports; lower index = older in program order.
- VLEN, 64: virtual address width.
- TransIdBits, 3: scoreboard transaction id width.
- UpdDepth, 4: predictor-update FIFO depth; must be >= NrBrPorts and a power of two.
- RVC, 1: compressed ISA enabled; 0 makes bit 1 of a taken target misaligned.
- clk_i  in  1  subsystem clock.
- rst_ni  in  1  asynchronous reset, active low.
- flush_i  in  1  controller flush; clears HALT and the output stage.
- valid_i  in  NrBrPorts  per-port instruction valid.
- op_i  in  NrBrPorts x br_op_t  BR_COND, JAL or JALR.
- trans_id_i  in  NrBrPorts x TransIdBits  scoreboard id.
- pc_i, operand_a_i, imm_i  in  NrBrPorts x VLEN  PC, rs1 and sign-extended immediate.
- is_compressed_i  in  NrBrPorts  2-byte instruction.
- comp_res_i  in  NrBrPorts  ALU compare result; 1 = taken.
- pred_cf_i  in  NrBrPorts x cf_t  predicted type: NoCF, Branch, Jump, JumpR or Return.
- pred_addr_i  in  NrBrPorts x VLEN  predicted target.
- ready_o  out  1  unit accepts inputs this cycle.
- result_valid_o  out  NrBrPorts  writeback valid.
- result_o  out  NrBrPorts x VLEN  link value (next_pc).
- result_id_o  out  NrBrPorts x TransIdBits  writeback id.
- ex_valid_o  out  NrBrPorts  instruction-address-misaligned exception, tval = pc.
- mispredict_o  out  1  a redirect is required.
- redirect_pc_o  out  VLEN  correct next fetch address.
- resolve_branch_o  out  1  any port resolved this cycle.
- upd_valid_o / upd_ready_i  out / in  1  predictor-update handshake.
- upd_o  out  bp_update_t  {pc, target, is_taken, cf_type}.

## Operation
- Per port, combinationally:
  - next_pc = pc + (is_compressed ? 2 : 4).
  - base = (op == JALR) ? operand_a : pc.
  - target = base + imm, modulo 2^VLEN; for JALR, bit 0 of the target is cleared.
- taken: BR_COND uses comp_res; JAL and JALR are always taken.
- Mispredict rules:
  - BR_COND: mispredicted if comp_res != (pred_cf == Branch).
  - JALR: mispredicted if pred_cf == NoCF or target != pred_addr.
  - JAL: never mispredicted.
- Correct next PC: target if taken, else next_pc.
- Misaligned exception: taken && (target[0] || (!RVC && target[1])). A port with an exception never reports a mispredict.
- Arbitration: only the lowest-index valid port with a mispredict reports it. All higher-index ports in the same cycle are squashed: no writeback, no update, no exception.
- FSM, two states:
  - RUN: resolve normally. On a reported mispredict, go to HALT.
  - HALT: ready_o = 0 and valid_i is ignored. flush_i returns the FSM to RUN.
  - flush_i in RUN clears the output register only.
- Update entries are pushed in port order for every non-squashed BR_COND, and for any JALR that mispredicts.
  - cf_type is Branch for BR_COND.
  - For a JALR, cf_type is JumpR, or stays Return if predicted Return.
- ready_o = (state == RUN) && (free FIFO entries >= NrBrPorts).
- Inputs presented while ready_o = 0 are a protocol error; an SVA checks for it.

## Timing
- Resolution outputs are registered with 1-cycle latency: result_*, ex_valid_o, mispredict_o, redirect_pc_o, resolve_branch_o.
- mispredict_o is a single-cycle pulse.
- The FIFO is first-word-fall-through. upd_valid_o is high whenever the FIFO is non-empty; a pop happens when upd_valid_o && upd_ready_i.
- Push and pop may occur in the same cycle. Occupancy is updated as occupancy + pushes - pops and never exceeds UpdDepth.
- Read and write pointers wrap modulo UpdDepth.
- flush_i in the same cycle as valid_i: flush wins, and that cycle's inputs are dropped entirely.
- flush_i does not clear the FIFO; training survives a flush.
- Reset (asynchronous, at any time): FSM = RUN, FIFO empty, pointers = 0, and all outputs = 0. After reset ready_o = 1 and upd_valid_o = 0.

## Structure
- ariane_pkg holds br_op_t, bp_update_t and a function br_resolve() that computes target, taken, mispredict and exception for one port. cf_t is reused from ariane_pkg.
- Sub-module branch_upd_fifo: a multi-push, single-pop FIFO parametrised on depth, push width and entry type.

## Test plan
- Port0 BR_COND, pc=0x1000, imm=0x20, comp_res=1, pred_cf=NoCF -> next cycle mispredict_o=1, redirect_pc_o=0x1020, FSM in HALT; one update entry {0x1000, 0x1020, taken, Branch}.
- Port0 JAL (no mispredict) and port1 JALR mispredict in the same cycle -> both write back, redirect from port1. Then both ports mispredict -> redirect from port0 and port1 is squashed.
- JALR with operand_a=0x2003, imm=0 -> target 0x2002. With RVC=1: no exception. With RVC=0: ex_valid_o=1 and tval=pc.
- Hold upd_ready_i=0 for two cycles of 2-port BR_COND with UpdDepth=4 -> ready_o drops after the second push. Then pop one entry per cycle and check ready_o returns only once free >= 2.
- Assert flush_i together with valid_i while in HALT -> inputs dropped, FSM in RUN, FIFO contents preserved.
- Assert rst_ni low mid-stream with the FIFO holding 3 entries -> all outputs 0, upd_valid_o=0 and ready_o=1 immediately after reset.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared types for branch resolution: operation/control-flow enums, predictor
// update record and the per-port resolve function.
package ariane_pkg;

    localparam int BpVlen = 64;

    typedef enum logic [1:0] {BR_COND, JAL, JALR} br_op_t;

    typedef enum logic [2:0] {NoCF, Branch, Jump, JumpR, Return} cf_t;

    typedef enum logic {ST_RUN, ST_HALT} br_state_e;

    typedef struct packed {
        logic [BpVlen-1:0] pc;
        logic [BpVlen-1:0] target;
        logic              is_taken;
        cf_t               cf_type;
    } bp_update_t;

    typedef struct packed {
        logic [BpVlen-1:0] next_pc;
        logic [BpVlen-1:0] target;
        logic [BpVlen-1:0] redirect;
        logic              taken;
        logic              mispredict;
        logic              ex;
    } br_res_t;

    function automatic br_res_t br_resolve(
        input br_op_t            op,
        input logic [BpVlen-1:0] pc,
        input logic [BpVlen-1:0] opa,
        input logic [BpVlen-1:0] imm,
        input logic              is_comp,
        input logic              comp_res,
        input cf_t               pred_cf,
        input logic [BpVlen-1:0] pred_addr,
        input logic              rvc
    );
        br_res_t r;
        logic    misp_raw;
        r.next_pc = pc + (is_comp ? BpVlen'(2) : BpVlen'(4));
        r.target  = ((op == JALR) ? opa : pc) + imm;
        if (op == JALR) begin
            r.target[0] = 1'b0;
        end
        r.taken = (op == BR_COND) ? comp_res : 1'b1;
        case (op)
            BR_COND: misp_raw = (comp_res != (pred_cf == Branch));
            JALR:    misp_raw = (pred_cf == NoCF) || (r.target != pred_addr);
            default: misp_raw = 1'b0;
        endcase
        // A faulting instruction traps instead of redirecting.
        r.ex         = r.taken && (r.target[0] || (!rvc && r.target[1]));
        r.mispredict = misp_raw && !r.ex;
        r.redirect   = r.taken ? r.target : r.next_pc;
        return r;
    endfunction

endpackage

// File: rtl/branch_upd_fifo.sv
// Multi-push, single-pop first-word-fall-through FIFO; valid push lanes are
// packed into consecutive slots in lane order.
module branch_upd_fifo #(
    parameter int  Depth = 4,
    parameter int  PushW = 2,
    parameter type T     = logic,
    localparam int AddrW = $clog2(Depth),
    localparam int CntW  = AddrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [PushW-1:0] push_i,
    input  T     [PushW-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output T                 data_o,
    output logic [CntW-1:0]  free_o
);

    T     [Depth-1:0] mem_q, mem_d;
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [CntW-1:0]  npush;
    logic [AddrW-1:0] slot;
    logic             pop;

    assign valid_o = (cnt_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign free_o  = CntW'(Depth) - cnt_q;
    assign pop     = valid_o && pop_i;

    always_comb begin
        mem_d = mem_q;
        slot  = wr_ptr_q;
        npush = '0;
        for (int i = 0; i < PushW; i++) begin
            if (push_i[i]) begin
                mem_d[slot] = push_data_i[i];
                slot        = slot + AddrW'(1);
                npush       = npush + CntW'(1);
            end
        end
        wr_ptr_d = slot;
        rd_ptr_d = rd_ptr_q + AddrW'(pop);
        cnt_d    = cnt_q + npush - CntW'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_d <= CntW'(Depth));

endmodule

// File: rtl/branch_unit_mc.sv
// Multi-port branch resolution: registered writeback/redirect, oldest-mispredict
// arbitration with halt-until-flush, and a buffered predictor-update queue.
module branch_unit_mc
    import ariane_pkg::*;
#(
    parameter int NrBrPorts   = 2,
    parameter int VLEN        = BpVlen,
    parameter int TransIdBits = 3,
    parameter int UpdDepth    = 4,
    parameter bit RVC         = 1'b1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  flush_i,
    input  logic [NrBrPorts-1:0]                  valid_i,
    input  br_op_t [NrBrPorts-1:0]                op_i,
    input  logic [NrBrPorts-1:0][TransIdBits-1:0] trans_id_i,
    input  logic [NrBrPorts-1:0][VLEN-1:0]        pc_i,
    input  logic [NrBrPorts-1:0][VLEN-1:0]        operand_a_i,
    input  logic [NrBrPorts-1:0][VLEN-1:0]        imm_i,
    input  logic [NrBrPorts-1:0]                  is_compressed_i,
    input  logic [NrBrPorts-1:0]                  comp_res_i,
    input  cf_t [NrBrPorts-1:0]                   pred_cf_i,
    input  logic [NrBrPorts-1:0][VLEN-1:0]        pred_addr_i,
    output logic                                  ready_o,
    output logic [NrBrPorts-1:0]                  result_valid_o,
    output logic [NrBrPorts-1:0][VLEN-1:0]        result_o,
    output logic [NrBrPorts-1:0][TransIdBits-1:0] result_id_o,
    output logic [NrBrPorts-1:0]                  ex_valid_o,
    output logic                                  mispredict_o,
    output logic [VLEN-1:0]                       redirect_pc_o,
    output logic                                  resolve_branch_o,
    output logic                                  upd_valid_o,
    input  logic                                  upd_ready_i,
    output bp_update_t                            upd_o
);

    localparam int CntW = $clog2(UpdDepth) + 1;

    br_state_e state_q, state_d;
    br_res_t    [NrBrPorts-1:0] res;
    bp_update_t [NrBrPorts-1:0] upd_entry;
    logic [NrBrPorts-1:0] act, push;
    logic                 hit;
    logic [VLEN-1:0]      redir;
    logic [CntW-1:0]      fifo_free;

    logic [NrBrPorts-1:0]                  result_valid_q, result_valid_d;
    logic [NrBrPorts-1:0][VLEN-1:0]        result_q, result_d;
    logic [NrBrPorts-1:0][TransIdBits-1:0] result_id_q, result_id_d;
    logic [NrBrPorts-1:0]                  ex_valid_q, ex_valid_d;
    logic                                  mispredict_q, mispredict_d;
    logic [VLEN-1:0]                       redirect_pc_q, redirect_pc_d;
    logic                                  resolve_q, resolve_d;

    assign ready_o = (state_q == ST_RUN) && (fifo_free >= CntW'(NrBrPorts));
    // A flush in the same cycle drops the inputs entirely.
    assign act = valid_i & {NrBrPorts{ready_o && !flush_i}};

    // Resolve stage: walk ports oldest first; everything after the first mispredict is squashed.
    always_comb begin
        hit            = 1'b0;
        redir          = '0;
        push           = '0;
        upd_entry      = '0;
        result_valid_d = '0;
        result_d       = '0;
        result_id_d    = '0;
        ex_valid_d     = '0;
        for (int i = 0; i < NrBrPorts; i++) begin
            res[i] = br_resolve(op_i[i], pc_i[i], operand_a_i[i], imm_i[i], is_compressed_i[i],
                                comp_res_i[i], pred_cf_i[i], pred_addr_i[i], RVC);
            if (act[i] && !hit) begin
                result_valid_d[i]      = 1'b1;
                result_d[i]            = res[i].next_pc;
                result_id_d[i]         = trans_id_i[i];
                ex_valid_d[i]          = res[i].ex;
                push[i]                = (op_i[i] == BR_COND) || ((op_i[i] == JALR) && res[i].mispredict);
                upd_entry[i].pc        = pc_i[i];
                upd_entry[i].target    = res[i].target;
                upd_entry[i].is_taken  = res[i].taken;
                if (op_i[i] == BR_COND) begin
                    upd_entry[i].cf_type = Branch;
                end else begin
                    upd_entry[i].cf_type = (pred_cf_i[i] == Return) ? Return : JumpR;
                end
                if (res[i].mispredict) begin
                    hit   = 1'b1;
                    redir = res[i].redirect;
                end
            end
        end
        mispredict_d  = hit;
        redirect_pc_d = redir;
        resolve_d     = |act;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (hit) state_d = ST_HALT;
            ST_HALT: if (flush_i) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // Output stage: one-cycle registered view of the resolve stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_RUN;
            result_valid_q <= '0;
            result_q       <= '0;
            result_id_q    <= '0;
            ex_valid_q     <= '0;
            mispredict_q   <= 1'b0;
            redirect_pc_q  <= '0;
            resolve_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            result_valid_q <= result_valid_d;
            result_q       <= result_d;
            result_id_q    <= result_id_d;
            ex_valid_q     <= ex_valid_d;
            mispredict_q   <= mispredict_d;
            redirect_pc_q  <= redirect_pc_d;
            resolve_q      <= resolve_d;
        end
    end

    assign result_valid_o   = result_valid_q;
    assign result_o         = result_q;
    assign result_id_o      = result_id_q;
    assign ex_valid_o       = ex_valid_q;
    assign mispredict_o     = mispredict_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign resolve_branch_o = resolve_q;

    branch_upd_fifo #(
        .Depth (UpdDepth),
        .PushW (NrBrPorts),
        .T     (bp_update_t)
    ) u_upd_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .push_data_i (upd_entry),
        .pop_i       (upd_ready_i),
        .valid_o     (upd_valid_o),
        .data_o      (upd_o),
        .free_o      (fifo_free)
    );

    a_valid_needs_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (|valid_i && !flush_i) |-> ready_o);

endmodule
